// File: rtl/mole_button_scanner.sv
// Scanned key-matrix front end: one active-low column per 4-cycle slot, rows sampled through a 2-flop synchronizer.
// Each key is debounced per scan and a press is reported one cycle after its last qualifying sample; there is no backpressure, and hits are single-cycle pulses.
module mole_button_scanner #(
  parameter int N_COLS         = 2,
  parameter int N_ROWS         = 4,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int N_KEYS = N_COLS * N_ROWS,
  localparam int CODE_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk_1k,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_n,
  output logic [N_COLS-1:0] col_n,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_hit,
  output logic              hit_valid,
  output logic [CODE_W-1:0] hit_code
);

  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [COL_W-1:0]             col_idx;
  logic [1:0]                   phase;
  logic                         sample;
  logic [N_ROWS-1:0]            row_s1;
  logic [N_ROWS-1:0]            row_s2;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt_nxt;
  logic [N_KEYS-1:0]            down_nxt;
  logic [N_KEYS-1:0]            hit_nxt;
  logic [CODE_W-1:0]            code_nxt;

  // Phases 0-2 give the column drive time to settle and cross the synchronizer.
  assign sample = (phase == 2'd3);

  always_ff @(posedge clk_1k) begin
    if (rst) begin
      phase   <= 2'd0;
      col_idx <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (sample) begin
        if (col_idx == COL_W'(N_COLS - 1)) col_idx <= '0;
        else                               col_idx <= col_idx + COL_W'(1);
      end
    end
  end

  always_comb begin
    col_n          = '1;
    col_n[col_idx] = 1'b0;
  end

  always_ff @(posedge clk_1k) begin
    if (rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // A counter only advances while its sample disagrees with the debounced state.
  always_comb begin
    down_nxt = key_down;
    hit_nxt  = '0;
    cnt_nxt  = cnt;
    for (int k = 0; k < N_KEYS; k++) begin
      if (sample && (col_idx == COL_W'(k / N_ROWS))) begin
        if (row_s2[k % N_ROWS] != key_down[k]) begin
          cnt_nxt[k] = '0;
        end else if (cnt[k] == CNT_W'(DEBOUNCE_SCANS - 1)) begin
          cnt_nxt[k]  = '0;
          down_nxt[k] = ~key_down[k];
          hit_nxt[k]  = ~key_down[k];
        end else begin
          cnt_nxt[k] = cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    code_nxt = hit_code;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (hit_nxt[k]) code_nxt = CODE_W'(k);
    end
  end

  always_ff @(posedge clk_1k) begin
    if (rst) begin
      cnt       <= '0;
      key_down  <= '0;
      key_hit   <= '0;
      hit_valid <= 1'b0;
      hit_code  <= '0;
    end else begin
      cnt       <= cnt_nxt;
      key_down  <= down_nxt;
      key_hit   <= hit_nxt;
      hit_valid <= |hit_nxt;
      hit_code  <= code_nxt;
    end
  end

endmodule

// File: doc/mole_button_scanner.md
Name: mole_button_scanner

Overview:
- Scanned input front-end for the whack-a-mole player buttons: the input-side counterpart of the multiplexed two-digit score display.
- Drives one active-low column line at a time and samples active-low row lines through a synchronizer.
- Debounces every key per scan and emits a one-cycle hit pulse and encoded key code to the game FSM.
- Runs on the same 1 kHz scan clock as the display.

Parameters:
N_COLS, 2, number of column drive lines (one-hot active-low)
N_ROWS, 4, number of row sense lines (active-low, pulled up externally)
DEBOUNCE_SCANS, 4, consecutive identical samples required to change a key's debounced state (>=2)

Ports:
clk_1k  input  1  scan clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
row_n  input  N_ROWS  raw asynchronous row sense lines, 0 = key on active column pressed
col_n  output  N_COLS  column drive, active-low, exactly one bit low at all times
key_down  output  N_COLS*N_ROWS  debounced pressed state per key, 1 = pressed
key_hit  output  N_COLS*N_ROWS  one-cycle pulse per key on debounced press edge
hit_valid  output  1  one-cycle pulse when any key_hit bit is set
hit_code  output  clog2(N_COLS*N_ROWS)  index of lowest-numbered key hit in the current pulse; holds last value otherwise

Behaviour:
- Key index k = c*N_ROWS + r for column c and row r.
- Row sync: row_n passes through a 2-flop synchronizer; rst loads both stages to all-ones (released).
- Scan sequencer: col_idx (0..N_COLS-1) and phase (0..3). phase increments every cycle. At phase 3, col_idx advances and wraps N_COLS-1 -> 0. Scan period is 4*N_COLS cycles (8 at defaults).
- col_n = ~(1 << col_idx), decoded from registered col_idx. Phases 0-2 are settle/sync time. Phase 3 is the sample cycle: the synchronized rows reflect the current column.
- Debounce: one counter per key, width clog2(DEBOUNCE_SCANS+1). It updates only in the sample cycle of its own column, with raw = ~row_sync[r].
  - raw == key_down[k]: counter <= 0.
  - Otherwise counter increments.
  - When the incremented value equals DEBOUNCE_SCANS: key_down[k] toggles and the counter returns to 0.
- Hit generation: on the same edge that key_down[k] goes 0->1, key_hit[k] <= 1. All other bits <= 0 every cycle, so each pulse lasts exactly one cycle. The 1->0 transition produces no pulse.
- hit_valid is registered with key_hit. hit_code loads the lowest k among new hits only when hit_valid is set. Only one column is sampled per cycle, so simultaneous hits come from the same column. key_hit keeps all simultaneous bits set.
- Press latency: a key pressed before its column's sample n is reported after the edge closing sample n+DEBOUNCE_SCANS-1. Bounce shorter than DEBOUNCE_SCANS consecutive samples never changes key_down.
- Reset values:
  - col_idx = 0, phase = 0, so col_n = {1..1,0} (2'b10 at defaults).
  - key_down = 0, key_hit = 0, hit_valid = 0, hit_code = 0.
  - All counters = 0.
- Reset mid-operation discards all debounce progress and pressed state. A key held across reset is re-debounced from scratch and produces a fresh hit.
- A key held indefinitely yields exactly one hit. A release then re-press yields another hit only after full release debounce followed by full press debounce.

Test Plan:
- Reset, then idle (row_n = 4'b1111) -> col_n holds 2'b10 for cycles 0-3 and 2'b01 for cycles 4-7, repeating; key_down = 0, no hit_valid for 100 cycles.
- Bench matrix model presses key 1 (col0,row1) from cycle 0 -> key_down[1] and key_hit[1] high in cycle 28 (after samples at cycles 3, 11, 19, 27). hit_valid = 1 and hit_code = 1 in cycle 28; key_hit = 0 in cycle 29.
- Key 6 (col1,row2) pressed for only 3 scans, then released -> key_down[6] never set, no hit_valid.
- Keys 5 and 7 (col1) pressed together from cycle 0 -> in cycle 32, key_hit = 8'b1010_0000, hit_valid = 1, hit_code = 5.
- Key 1 held 200 cycles then released -> exactly one hit. key_down[1] falls 4 column-0 samples after release, with no pulse on the fall.
- Key 1 held, rst asserted one cycle at cycle 19 -> all outputs return to reset values. key_down[1] re-asserts with a new hit 28 cycles after rst deasserts.
